// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: widths, initial hash value, controller states
// and the message-schedule small-sigma functions.
package sha256_pkg;

   localparam int WORD_W    = 32;
   localparam int BLOCK_W   = 512;
   localparam int HASH_W    = 256;
   localparam int WIN_WORDS = 16;
   localparam int H_WORDS   = 8;

   // Initial chaining value {H0..H7}, H0 in the top word.
   localparam logic [HASH_W-1:0] SHA256_IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ROUND,
      ST_FINAL,
      ST_OUT
   } state_t;

   // sigma0 = rotr7 ^ rotr18 ^ shr3
   function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   // sigma1 = rotr17 ^ rotr19 ^ shr10
   function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_block_ctrl_msg_sched.sv
// Sliding 16-word message schedule window. Loads a whole block at once and,
// on each shift, drops W[0] and appends the next expanded word, so the word
// for the current round is always at the head of the window.
module sha256_msg_sched
   import sha256_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_load,
   input  logic [BLOCK_W-1:0] i_blk,
   input  logic               i_shift,
   output logic [WORD_W-1:0]  o_wt
);

   logic [WORD_W-1:0] r_win [WIN_WORDS];
   logic [WORD_W-1:0] w_new;

   assign w_new = small_sigma1(r_win[14]) + r_win[9] + small_sigma0(r_win[1]) + r_win[0];

   genvar gi;
   generate
      for (gi = 0; gi < WIN_WORDS; gi++) begin : g_win
         logic [WORD_W-1:0] w_shift_in;

         if (gi == WIN_WORDS - 1) begin : g_tail
            assign w_shift_in = w_new;
         end else begin : g_body
            assign w_shift_in = r_win[gi+1];
         end

         // Each slot takes its block word on load, its right neighbour on a shift.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_win[gi] <= '0;
            end else if (i_load) begin
               r_win[gi] <= i_blk[BLOCK_W-1-WORD_W*gi -: WORD_W];
            end else if (i_shift) begin
               r_win[gi] <= w_shift_in;
            end
         end
      end
   endgenerate

   assign o_wt = r_win[0];

endmodule

// File: rtl/sha256_block_ctrl.sv
// Block sequencer for a one-round-per-clock SHA-256 core and its registered
// K ROM: accepts blocks, loads the chaining value, drives 64 rounds with the
// matching Wt/K address, folds the result into H and hands out the digest.
module sha256_block_ctrl
   import sha256_pkg::*;
#(
   parameter int ROUNDS = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               blk_valid,
   output logic               blk_ready,
   input  logic [BLOCK_W-1:0] blk_data,
   input  logic               blk_first,
   input  logic               blk_last,
   output logic               core_load,
   output logic [HASH_W-1:0]  core_init,
   output logic               core_round_en,
   output logic [5:0]         k_addr,
   output logic [WORD_W-1:0]  wt,
   input  logic [HASH_W-1:0]  core_state,
   output logic               dig_valid,
   input  logic               dig_ready,
   output logic [HASH_W-1:0]  digest,
   output logic               busy
);

   localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

   state_t              r_state;
   logic [HASH_W-1:0]   r_h;
   logic [5:0]          r_t;
   logic                r_last;
   logic                r_core_load;
   logic                r_round_en;
   logic [5:0]          r_k_addr;
   logic                r_dig_valid;
   logic                w_accept;
   logic [HASH_W-1:0]   w_h_sum;

   assign blk_ready = (r_state == ST_IDLE) && !rst;
   assign w_accept  = blk_valid && blk_ready;

   sha256_msg_sched u_sched (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_accept),
      .i_blk   (blk_data),
      .i_shift (r_state == ST_ROUND),
      .o_wt    (wt)
   );

   // Per-word chaining update; words are added independently with no carry.
   genvar gi;
   generate
      for (gi = 0; gi < H_WORDS; gi++) begin : g_fold
         assign w_h_sum[WORD_W*gi +: WORD_W] =
            r_h[WORD_W*gi +: WORD_W] + core_state[WORD_W*gi +: WORD_W];
      end
   endgenerate

   // Block FSM with registered strobes. k_addr runs one ahead of the round
   // because the K ROM has one cycle of read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_h         <= SHA256_IV;
         r_t         <= '0;
         r_last      <= 1'b0;
         r_core_load <= 1'b0;
         r_round_en  <= 1'b0;
         r_k_addr    <= '0;
         r_dig_valid <= 1'b0;
      end else begin
         r_core_load <= 1'b0;
         r_round_en  <= 1'b0;
         r_k_addr    <= '0;
         r_dig_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_last      <= blk_last;
                  if (blk_first) begin
                     r_h <= SHA256_IV;
                  end
                  r_core_load <= 1'b1;
                  r_state     <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_t        <= '0;
               r_round_en <= 1'b1;
               r_k_addr   <= 6'd1;
               r_state    <= ST_ROUND;
            end
            ST_ROUND: begin
               if (r_t == LAST_T) begin
                  r_state <= ST_FINAL;
               end else begin
                  r_t        <= r_t + 6'd1;
                  r_round_en <= 1'b1;
                  r_k_addr   <= r_t + 6'd2;
               end
            end
            ST_FINAL: begin
               r_h <= w_h_sum;
               if (r_last) begin
                  r_dig_valid <= 1'b1;
                  r_state     <= ST_OUT;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_OUT: begin
               if (dig_ready) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_dig_valid <= 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign core_load     = r_core_load;
   assign core_init     = r_h;
   assign core_round_en = r_round_en;
   assign k_addr        = r_k_addr;
   assign dig_valid     = r_dig_valid && !rst;
   assign digest        = r_h;
   assign busy          = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Self-checking bench for sha256_block_ctrl with a behavioural round core and
// K ROM as siblings; expected digests come from published vectors or from a
// plain SHA-256 compression function kept in the bench.
module tb_sha256_block_ctrl;

   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   localparam logic [31:0] K_TAB [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
   localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
   localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

   localparam logic [255:0] DIG_ABC   =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] DIG_EMPTY =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] DIG_TWO   =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

   typedef struct {
      logic [511:0] blk;
      logic         first;
      logic         last;
      int           stall;
      int           bp;
      logic         kat;
      logic [255:0] exp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         blk_valid;
   logic         blk_ready;
   logic [511:0] blk_data;
   logic         blk_first;
   logic         blk_last;
   logic         core_load;
   logic [255:0] core_init;
   logic         core_round_en;
   logic [5:0]   k_addr;
   logic [31:0]  wt;
   logic [255:0] core_state;
   logic         dig_valid;
   logic         dig_ready;
   logic [255:0] digest;
   logic         busy;

   int checks = 0;
   int errors = 0;
   logic [255:0] model_h;
   logic [31:0]  ref_w [64];
   logic [31:0]  k_q;

   always #5 clk = ~clk;

   sha256_block_ctrl dut (
      .clk           (clk),
      .rst           (rst),
      .blk_valid     (blk_valid),
      .blk_ready     (blk_ready),
      .blk_data      (blk_data),
      .blk_first     (blk_first),
      .blk_last      (blk_last),
      .core_load     (core_load),
      .core_init     (core_init),
      .core_round_en (core_round_en),
      .k_addr        (k_addr),
      .wt            (wt),
      .core_state    (core_state),
      .dig_valid     (dig_valid),
      .dig_ready     (dig_ready),
      .digest        (digest),
      .busy          (busy)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] round_fn(input logic [255:0] s, input logic [31:0] k,
                                             input logic [31:0] w);
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      {a, b, c, d, e, f, g, h} = s;
      t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      return {t1 + t2, a, b, c, d + t1, e, f, g};
   endfunction

   // Full message expansion W0..W63 straight from the SHA-256 recurrence.
   function automatic void ref_expand(input logic [511:0] blk);
      for (int t = 0; t < 64; t++) begin
         if (t < 16) begin
            ref_w[t] = blk[511 - 32*t -: 32];
         end else begin
            ref_w[t] = (rotr(ref_w[t-2], 17) ^ rotr(ref_w[t-2], 19) ^ (ref_w[t-2] >> 10))
                     + ref_w[t-7]
                     + (rotr(ref_w[t-15], 7) ^ rotr(ref_w[t-15], 18) ^ (ref_w[t-15] >> 3))
                     + ref_w[t-16];
         end
      end
   endfunction

   function automatic logic [255:0] ref_compress(input logic [255:0] h, input logic [511:0] blk);
      logic [255:0] s, r;
      ref_expand(blk);
      s = h;
      for (int t = 0; t < 64; t++) s = round_fn(s, K_TAB[t], ref_w[t]);
      for (int i = 0; i < 8; i++) r[32*i +: 32] = h[32*i +: 32] + s[32*i +: 32];
      return r;
   endfunction

   // Sibling models: registered K ROM and one-round-per-clock core.
   logic [255:0] core_q;
   always @(posedge clk) begin
      k_q <= K_TAB[k_addr];
      if (core_load) core_q <= core_init;
      else if (core_round_en) core_q <= round_fn(core_q, k_q, wt);
   end
   assign core_state = core_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] rand_block();
      logic [511:0] b;
      for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
      return b;
   endfunction

   // Offer one block, follow it cycle by cycle through LOAD/ROUND/FINAL and
   // the digest handshake if it is the last block of a message.
   task automatic run_block(input vec_t v, input logic hold_dready, input string tag);
      logic [255:0] h_start, h_exp, d_req;
      int n;
      h_start = v.first ? IV : model_h;
      h_exp   = ref_compress(h_start, v.blk);
      model_h = h_exp;
      d_req   = v.kat ? v.exp : h_exp;
      blk_valid = 1'b0;
      for (int i = 0; i < v.stall; i++) begin
         tick();
         check({tag, " stall"}, {busy, blk_ready, dig_valid}, 3'b010);
      end
      blk_valid = 1'b1;
      blk_data  = v.blk;
      blk_first = v.first;
      blk_last  = v.last;
      dig_ready = hold_dready;
      n = 0;
      while (blk_ready !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check({tag, " ready"}, blk_ready, 1'b1);
      tick();
      blk_valid = 1'b0;
      blk_data  = rand_block();
      blk_first = 1'($urandom());
      blk_last  = 1'($urandom());
      check({tag, " load"}, {core_load, core_round_en, dig_valid, blk_ready, busy, k_addr},
            {5'b10001, 6'd0});
      check({tag, " init"}, core_init, h_start);
      for (int t = 0; t < 64; t++) begin
         tick();
         check({tag, " round"}, {core_load, core_round_en, dig_valid, blk_ready, k_addr, wt},
               {4'b0100, 6'((t + 1) % 64), ref_w[t]});
      end
      tick();
      check({tag, " final"}, {core_load, core_round_en, dig_valid, blk_ready, busy}, 5'b00001);
      tick();
      if (v.last) begin
         check({tag, " dvalid"}, {dig_valid, blk_ready, busy}, 3'b101);
         check({tag, " digest"}, digest, d_req);
         if (v.bp > 0) dig_ready = 1'b0;
         for (int i = 0; i < v.bp; i++) begin
            tick();
            check({tag, " hold"}, {dig_valid, blk_ready, core_round_en}, 3'b100);
            check({tag, " stable"}, digest, d_req);
         end
         dig_ready = 1'b1;
         tick();
         dig_ready = 1'b0;
         check({tag, " release"}, {dig_valid, blk_ready, busy}, 3'b010);
      end else begin
         check({tag, " next"}, {dig_valid, blk_ready, busy}, 3'b010);
      end
      dig_ready = 1'b0;
      $display("blk %s first=%0d last=%0d stall=%0d bp=%0d digest=%h",
               tag, v.first, v.last, v.stall, v.bp, digest);
   endtask

   vec_t vecs [6];
   vec_t rv;
   int   n;

   initial begin
      rst       = 1'b1;
      blk_valid = 1'b0;
      blk_data  = '0;
      blk_first = 1'b0;
      blk_last  = 1'b0;
      dig_ready = 1'b0;
      model_h   = IV;

      vecs[0] = '{BLK_ABC,   1'b1, 1'b1, 0, 0,  1'b1, DIG_ABC};
      vecs[1] = '{BLK_EMPTY, 1'b1, 1'b1, 0, 0,  1'b1, DIG_EMPTY};
      vecs[2] = '{BLK_TWO1,  1'b1, 1'b0, 0, 0,  1'b0, 256'h0};
      vecs[3] = '{BLK_TWO2,  1'b0, 1'b1, 5, 0,  1'b1, DIG_TWO};
      vecs[4] = '{BLK_ABC,   1'b1, 1'b1, 0, 10, 1'b1, DIG_ABC};
      vecs[5] = '{BLK_ABC,   1'b1, 1'b1, 0, 0,  1'b1, DIG_ABC};

      // Reset state.
      repeat (3) tick();
      check("rst outputs", {blk_ready, core_load, core_round_en, dig_valid, busy, k_addr},
            11'b0);
      check("rst wt", wt, 32'h0);
      check("rst digest", digest, IV);
      rst = 1'b0;
      tick();
      check("post rst ready", {blk_ready, busy}, 2'b10);

      // Known-answer vectors, two-block chaining and digest backpressure.
      for (int i = 0; i < 6; i++) run_block(vecs[i], 1'b0, $sformatf("kat%0d", i));

      // Reset in the middle of round 30 abandons the block and restores IV.
      blk_valid = 1'b1;
      blk_data  = BLK_ABC;
      blk_first = 1'b1;
      blk_last  = 1'b1;
      n = 0;
      while (blk_ready !== 1'b1 && n < 300) begin
         tick();
         n++;
      end
      check("rst30 ready", blk_ready, 1'b1);
      tick();
      blk_valid = 1'b0;
      repeat (31) tick();
      check("rst30 round", {core_round_en, k_addr}, {1'b1, 6'd31});
      rst = 1'b1;
      tick();
      check("rst30 idle", {busy, core_round_en, core_load, dig_valid, blk_ready}, 5'b0);
      check("rst30 h", digest, IV);
      rst = 1'b0;
      tick();
      check("rst30 after", {blk_ready, busy, core_round_en}, 3'b100);
      model_h = 256'h0;   // blk_first=0 below must fall back on the reset IV
      rv = '{BLK_ABC, 1'b0, 1'b1, 0, 0, 1'b1, DIG_ABC};
      model_h = IV;
      run_block(rv, 1'b0, "rst30 abc");

      // Random blocks and chaining against the reference compression model.
      for (int i = 0; i < 10; i++) begin
         rv.blk   = rand_block();
         rv.first = (i == 0) || ($urandom_range(0, 3) == 0);
         rv.last  = (i == 9) || ($urandom_range(0, 2) == 0);
         rv.stall = $urandom_range(0, 3);
         rv.bp    = $urandom_range(0, 4);
         rv.kat   = 1'b0;
         rv.exp   = 256'h0;
         run_block(rv, 1'($urandom()), $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
